// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   // Even parity of a word, zero-extended to MAX_WIDTH by the caller.
   function automatic logic word_parity(input logic [MAX_WIDTH-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/bit_counter.sv
// Counts presented frame bits; last flags the bit index WIDTH-1.
module bit_counter
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       inc,
   output logic [$clog2(WIDTH)-1:0]   count,
   output logic                       last
);

   localparam int unsigned CW = $clog2(WIDTH);

   // clear wins over inc so a new frame always starts at bit 0
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_tx.sv
// LSB-first parallel-to-serial transmitter with ready/valid load handshake.
// Define PISO_SHIFT_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [WIDTH-1:0]   load_data,
   output logic               sout,
   output logic               sout_valid,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t             r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [CW-1:0]      w_count;
   logic               w_last;
   logic               w_xfer;
   logic               w_clear;
   logic               w_inc;
`ifdef PISO_SHIFT_TX_PARITY_EN
   logic               r_parity;
`else
   logic               w_next_last;
`endif

   assign w_xfer  = load_valid & load_ready;
   assign w_clear = w_xfer | (r_state == IDLE);
   assign w_inc   = (r_state == SHIFT) & ~w_last & ~w_xfer;
`ifndef PISO_SHIFT_TX_PARITY_EN
   assign w_next_last = (w_count == CW'(WIDTH - 2));
`endif

   bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .inc   (w_inc),
      .count (w_count),
      .last  (w_last)
   );

   // Outputs are registered and describe the cycle being entered, so done and
   // load_ready rise together with the final frame bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else if (w_xfer) begin
         r_state    <= SHIFT;
         r_shreg    <= {1'b0, load_data[WIDTH-1:1]};
         sout       <= load_data[0];
         sout_valid <= 1'b1;
         busy       <= 1'b1;
         done       <= 1'b0;
         load_ready <= 1'b0;
`ifdef PISO_SHIFT_TX_PARITY_EN
         r_parity   <= word_parity(MAX_WIDTH'(load_data));
`endif
      end else begin
         case (r_state)
            SHIFT: begin
               if (w_last) begin
`ifdef PISO_SHIFT_TX_PARITY_EN
                  r_state    <= PARITY;
                  sout       <= r_parity;
                  sout_valid <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b1;
                  load_ready <= 1'b1;
`else
                  r_state    <= IDLE;
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b0;
                  load_ready <= 1'b1;
`endif
               end else begin
                  r_shreg    <= {1'b0, r_shreg[WIDTH-1:1]};
                  sout       <= r_shreg[0];
                  sout_valid <= 1'b1;
                  busy       <= 1'b1;
`ifdef PISO_SHIFT_TX_PARITY_EN
                  done       <= 1'b0;
                  load_ready <= 1'b0;
`else
                  done       <= w_next_last;
                  load_ready <= w_next_last;
`endif
               end
            end
            default: begin
               r_state    <= IDLE;
               sout       <= 1'b0;
               sout_valid <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed table-driven bench for piso_shift_tx (WIDTH=4), both parity builds.
module tb_piso_shift_tx;

   localparam int unsigned WIDTH = 4;
`ifdef PISO_SHIFT_TX_PARITY_EN
   localparam int unsigned FRAME_BITS = 5;
`else
   localparam int unsigned FRAME_BITS = 4;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic             sout;
   logic             sout_valid;
   logic             busy;
   logic             done;

   // exp packs {load_ready, sout, sout_valid, busy, done} after the edge
   typedef struct {
      logic       rst;
      logic       lv;
      logic [3:0] ld;
      logic [4:0] exp;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   piso_shift_tx #(
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic lv, input logic [3:0] ld);
      @(negedge clk);
      reset      = r;
      load_valid = lv;
      load_data  = ld;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] obs();
      return {load_ready, sout, sout_valid, busy, done};
   endfunction

   task automatic add(input logic r, input logic lv, input logic [3:0] ld, input logic [4:0] e);
      vec_t v;
      v.rst = r;
      v.lv  = lv;
      v.ld  = ld;
      v.exp = e;
      vq.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [7:0] bits;
      int         n;
      bit         seen_done;

      reset      = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;

`ifdef PISO_SHIFT_TX_PARITY_EN
      add(1, 0, 4'h0, 5'b00000);
      add(0, 0, 4'h0, 5'b10000);
      add(0, 1, 4'hB, 5'b01110);
      add(0, 0, 4'h0, 5'b01110);
      add(0, 0, 4'h0, 5'b00110);
      add(0, 0, 4'h0, 5'b01110);
      add(0, 0, 4'h0, 5'b11111);   // parity of 1011 = 1
      add(0, 1, 4'h3, 5'b01110);   // accepted in parity cycle, gapless
      add(0, 0, 4'h0, 5'b01110);
      add(0, 0, 4'h0, 5'b00110);
      add(0, 0, 4'h0, 5'b00110);
      add(0, 0, 4'h0, 5'b10111);   // parity of 0011 = 0
      add(0, 0, 4'h0, 5'b10000);
      add(0, 1, 4'hB, 5'b01110);
      add(1, 0, 4'h0, 5'b00000);
      add(0, 0, 4'h0, 5'b10000);
`else
      add(1, 0, 4'h0, 5'b00000);
      add(0, 0, 4'h0, 5'b10000);
      add(0, 1, 4'hB, 5'b01110);   // 1011 -> 1,1,0,1
      add(0, 0, 4'h0, 5'b01110);
      add(0, 0, 4'h0, 5'b00110);
      add(0, 0, 4'h0, 5'b11111);
      add(0, 0, 4'h0, 5'b10000);
      add(0, 1, 4'hA, 5'b00110);   // A then held 5
      add(0, 1, 4'h5, 5'b01110);
      add(0, 1, 4'h5, 5'b00110);
      add(0, 1, 4'h5, 5'b11111);
      add(0, 1, 4'h5, 5'b01110);
      add(0, 0, 4'h0, 5'b00110);
      add(0, 0, 4'h0, 5'b01110);
      add(0, 0, 4'h0, 5'b10111);
      add(0, 0, 4'h0, 5'b10000);
      add(0, 1, 4'h6, 5'b00110);   // 0110 with load_data toggling
      add(0, 0, 4'hF, 5'b01110);
      add(0, 0, 4'h0, 5'b01110);
      add(0, 0, 4'hF, 5'b10111);
      add(0, 0, 4'h0, 5'b10000);
      add(0, 1, 4'hB, 5'b01110);   // reset in cycle 2
      add(0, 0, 4'h0, 5'b01110);
      add(1, 0, 4'h0, 5'b00000);
      add(0, 0, 4'h0, 5'b10000);
`endif

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].rst, vq[i].lv, vq[i].ld);
         check($sformatf("vec%0d", i), 32'(obs()), 32'(vq[i].exp));
      end

      // Whole frame of 4'h9 collected from the serial side, bounded wait for done
      bits      = '0;
      n         = 0;
      seen_done = 1'b0;
      step(0, 1, 4'h9);
      for (int c = 0; c < 12; c++) begin
         if (sout_valid && n < 8) begin
            bits[n] = sout;
            n++;
         end
         if (done) begin
            seen_done = 1'b1;
            check("ready_at_done", 32'(load_ready), 32'd1);
            break;
         end
         step(0, 0, 4'h0);
      end
      check("done_seen", 32'(seen_done), 32'd1);
      check("frame_len", 32'(n), 32'(FRAME_BITS));
      check("frame_data", 32'(bits[3:0]), 32'h9);
`ifdef PISO_SHIFT_TX_PARITY_EN
      check("frame_parity", 32'(bits[4]), 32'd0);
`endif
      step(0, 0, 4'h0);
      check("idle_after_frame", 32'(obs()), 32'b10000);

      // Reset in the final-bit cycle: no trailing activity, ready after release
      step(0, 1, 4'h7);
      for (int c = 1; c < FRAME_BITS; c++) step(0, 0, 4'h0);
      check("final_cycle_done", 32'(done), 32'd1);
      step(1, 0, 4'h0);
      check("reset_final_obs", 32'(obs()), 32'b00000);
      step(0, 0, 4'h0);
      check("reset_release_obs", 32'(obs()), 32'b10000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_shift_tx.md
PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits; legal range 2..32.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  producer offers load_data this cycle.
REQ-005 load_ready  output  1  block can accept a word this cycle.
REQ-006 load_data  input  WIDTH  parallel word to serialize.
REQ-007 sout  output  1  serial data bit, LSB first.
REQ-008 sout_valid  output  1  sout carries a frame bit this cycle.
REQ-009 busy  output  1  a frame is in progress.
REQ-010 done  output  1  high only in the cycle the final frame bit is on sout.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT and PARITY; PARITY exists only per REQ-024.
REQ-012 A transfer SHALL occur only on a cycle where load_valid and load_ready are both high; load_data is captured in that cycle.
REQ-013 load_ready SHALL be high in IDLE and in the final-bit cycle of a frame; it SHALL be low in all other cycles.
REQ-014 After a transfer the FSM SHALL enter SHIFT; the first bit, load_data[0], SHALL appear on sout the next cycle (latency 1).
REQ-015 In SHIFT the block SHALL present one bit per cycle, shifting right, in order bit 0 to bit WIDTH-1, with sout_valid high.
REQ-016 A bit counter SHALL count presented bits 0..WIDTH-1; its width SHALL be $clog2(WIDTH).
REQ-017 With parity disabled, the cycle presenting bit WIDTH-1 SHALL be the final-bit cycle.
REQ-018 A transfer in the final-bit cycle SHALL start the next frame's bit 0 the following cycle, with no gap and with sout_valid held high.
REQ-019 With no transfer in the final-bit cycle, the FSM SHALL return to IDLE; sout and sout_valid SHALL be 0 in IDLE.
REQ-020 busy SHALL equal (state != IDLE); done SHALL be high in the final-bit cycle only.
REQ-021 load_data changes while not transferring SHALL have no effect on the frame in progress.

Reset
REQ-022 While reset is high, the block SHALL reset the state to IDLE and clear the shift register, the counter, sout, sout_valid and done to 0; load_ready SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse; load_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-024 With macro PISO_SHIFT_TX_PARITY_EN defined, a PARITY state SHALL follow bit WIDTH-1 for one cycle.
- In PARITY, sout = even parity (XOR) of the captured word and sout_valid = 1.
- The PARITY cycle becomes the final-bit cycle for REQ-013/017/018/020.
REQ-025 Without the macro, the block SHALL have no PARITY state, no parity logic, and frames of exactly WIDTH bits.

Structure
REQ-026 Package piso_pkg SHALL hold the state enum typedef (IDLE, SHIFT, PARITY) and a parity function of the word.
REQ-027 The counter SHALL be the sub-module bit_counter, with ports clk, reset, clear, inc, count and last.
- last flags count == WIDTH-1.

Verification
REQ-028 With WIDTH=4, load 4'b1011 in IDLE, parity off -> sout 1,1,0,1 on cycles 1-4; sout_valid high for 4 cycles; done only in cycle 4; then IDLE.
REQ-029 Load 4'hA, then hold load_valid with 4'h5 -> 4'h5 accepted in cycle 4 (load_ready=1), not before; sout stream 0,1,0,1,1,0,1,0 is gapless.
REQ-030 With PISO_SHIFT_TX_PARITY_EN, load 4'b1011 -> sout 1,1,0,1,1 with the parity bit in cycle 5; done in cycle 5; 4'b0011 gives parity bit 0.
REQ-031 Reset asserted in cycle 2 of a frame -> next cycle sout=0, sout_valid=0, busy=0, no done; load_ready=1 after release.
REQ-032 Toggle load_data every cycle during a frame of 4'b0110 -> output is still 0,1,1,0.
